// File: rtl/bcd_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter:
// digit geometry, add-3 threshold, FSM states and counter sizing.
package bcd_pkg;

  localparam int         DIGIT_W     = 4;
  localparam logic [3:0] ADD3_THRESH = 4'd5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Iteration counter width; never narrower than one bit.
  function automatic int cnt_width(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/bcd_dabble_step.sv
// One combinational shift-and-add-3 iteration across all BCD digits.
// Shared between the sequential converter and the unrolled variant.
module bcd_dabble_step
  import bcd_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic [DIGIT_W*DIGITS-1:0] digits_in,
  input  logic                      bit_in,
  output logic [DIGIT_W*DIGITS-1:0] digits_out,
  output logic                      carry_out
);

  logic [DIGIT_W*DIGITS-1:0] adj;

  // Each digit is corrected on its own; no carry runs between digits.
  always_comb begin
    adj = digits_in;
    for (int k = 0; k < DIGITS; k++) begin
      if (digits_in[k*DIGIT_W +: DIGIT_W] >= ADD3_THRESH)
        adj[k*DIGIT_W +: DIGIT_W] = digits_in[k*DIGIT_W +: DIGIT_W] + 4'd3;
    end
  end

  assign {carry_out, digits_out} = {adj, bit_in};

endmodule

// File: rtl/bcd_seq_converter.sv
// Multi-cycle double-dabble binary-to-BCD converter, one iteration per clock.
// Optional leading-zero mask on digit_blank when BCD_SEQ_LEADZERO_EN is defined.
module bcd_seq_converter
  import bcd_pkg::*;
#(
  parameter int WIDTH  = 12,
  parameter int DIGITS = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [WIDTH-1:0]          bin_in,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DIGIT_W*DIGITS-1:0] bcd_out,
  output logic                      ovf,
  output logic [DIGITS-1:0]         digit_blank
);

  localparam int             CNT_W    = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WIDTH - 1);

  state_t                    state;
  logic [CNT_W-1:0]          cnt;
  logic [WIDTH-1:0]          sreg;
  logic [DIGIT_W*DIGITS-1:0] step_digits;
  logic                      step_carry;

  bcd_dabble_step #(
    .DIGITS (DIGITS)
  ) u_step (
    .digits_in  (bcd_out),
    .bit_in     (sreg[WIDTH-1]),
    .digits_out (step_digits),
    .carry_out  (step_carry)
  );

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      bcd_out <= '0;
      ovf     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            sreg    <= bin_in;
            bcd_out <= '0;
            ovf     <= 1'b0;
            cnt     <= CNT_LOAD;
            state   <= SHIFT;
          end
        end
        SHIFT: begin
          bcd_out <= step_digits;
          sreg    <= sreg << 1;
          if (step_carry)
            ovf <= 1'b1;
          if (cnt == '0)
            state <= DONE;
          else
            cnt <= cnt - 1'b1;
        end
        DONE: begin
          if (out_ready)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef BCD_SEQ_LEADZERO_EN
  // Bit k is set when digit k and every digit above it are zero; ones never blank.
  function automatic logic [DIGITS-1:0] lead_blank(input logic [DIGIT_W*DIGITS-1:0] d);
    logic [DIGITS-1:0] b;
    logic              z;
    b = '0;
    z = 1'b1;
    for (int k = DIGITS - 1; k >= 1; k--) begin
      z    = z && (d[k*DIGIT_W +: DIGIT_W] == '0);
      b[k] = z;
    end
    return b;
  endfunction

  always_ff @(posedge clk) begin
    if (rst)
      digit_blank <= '0;
    else if (state == SHIFT && cnt == '0)
      digit_blank <= lead_blank(step_digits);
  end
`else
  assign digit_blank = '0;
`endif

endmodule

// File: tb/tb_bcd_seq_converter.sv
// Self-checking bench for bcd_seq_converter: directed plan plus randomized
// conversions against an arithmetic decimal reference model.
module tb_bcd_seq_converter;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, out_valid, out_ready, ovf;
  logic [11:0] bin_in;
  logic [15:0] bcd_out;
  logic [3:0]  digit_blank;

  logic        in_valid14, in_ready14, out_valid14, out_ready14, ovf14;
  logic [13:0] bin_in14;
  logic [15:0] bcd_out14;
  logic [3:0]  digit_blank14;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  bcd_seq_converter #(.WIDTH(12), .DIGITS(4)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .bin_in(bin_in), .out_valid(out_valid), .out_ready(out_ready),
    .bcd_out(bcd_out), .ovf(ovf), .digit_blank(digit_blank)
  );

  bcd_seq_converter #(.WIDTH(14), .DIGITS(4)) u_dut14 (
    .clk(clk), .rst(rst), .in_valid(in_valid14), .in_ready(in_ready14),
    .bin_in(bin_in14), .out_valid(out_valid14), .out_ready(out_ready14),
    .bcd_out(bcd_out14), .ovf(ovf14), .digit_blank(digit_blank14)
  );

  // Reference: decimal digits by repeated division, no bit manipulation.
  function automatic logic [15:0] m_bcd(input int v);
    logic [15:0] r;
    int          x;
    r = '0;
    x = v;
    for (int d = 0; d < 4; d++) begin
      r[4*d +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic logic m_ovf(input int v);
    return v > 9999;
  endfunction

  function automatic logic [3:0] m_blank(input int v);
    logic [3:0] b;
    b = '0;
`ifdef BCD_SEQ_LEADZERO_EN
    if (v < 10)   b[1] = 1'b1;
    if (v < 100)  b[2] = 1'b1;
    if (v < 1000) b[3] = 1'b1;
`endif
    return b;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One 12-bit conversion; optional stall after out_valid and optional
  // stray in_valid pulse while the converter is busy.
  task automatic convert(input int v, input int stall, input bit inject);
    int k;
    k = 0;
    while (!in_ready && k < 50) begin
      @(posedge clk); #1; k++;
    end
    check("accept_ready", in_ready, 1);
    bin_in    = 12'(v);
    in_valid  = 1'b1;
    out_ready = (stall == 0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    bin_in   = 12'($urandom);
    k = 0;
    while (!out_valid && k < 40) begin
      check("busy_in_ready", in_ready, 0);
      if (inject && k == 3) begin
        in_valid = 1'b1;
        bin_in   = 12'd999;
      end else begin
        in_valid = 1'b0;
      end
      @(posedge clk); #1; k++;
    end
    in_valid = 1'b0;
    check("latency", k, 12);
    check("bcd", bcd_out, m_bcd(v));
    check("ovf", ovf, m_ovf(v));
    check("blank", digit_blank, m_blank(v));
    check("done_in_ready", in_ready, 0);
    for (int s = 0; s < stall; s++) begin
      @(posedge clk); #1;
      check("stall_valid", out_valid, 1);
      check("stall_bcd", bcd_out, m_bcd(v));
      check("stall_blank", digit_blank, m_blank(v));
      check("stall_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("idle_ready", in_ready, 1);
    check("idle_valid", out_valid, 0);
    check("idle_hold_bcd", bcd_out, m_bcd(v));
  endtask

  task automatic convert14(input int v);
    int k;
    bin_in14    = 14'(v);
    in_valid14  = 1'b1;
    out_ready14 = 1'b0;
    @(posedge clk); #1;
    in_valid14 = 1'b0;
    k = 0;
    while (!out_valid14 && k < 40) begin
      @(posedge clk); #1; k++;
    end
    check("latency14", k, 14);
    check("ovf14", ovf14, m_ovf(v));
    if (!m_ovf(v))
      check("bcd14", bcd_out14, m_bcd(v));
    out_ready14 = 1'b1;
    @(posedge clk); #1;
    check("idle14", in_ready14, 1);
    out_ready14 = 1'b0;
  endtask

  initial begin
    #5000000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

  initial begin
    int v;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; bin_in = '0;
    in_valid14 = 1'b0; out_ready14 = 1'b0; bin_in14 = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_bcd", bcd_out, 16'h0000);
    check("rst_ovf", ovf, 0);
    check("rst_blank", digit_blank, 4'b0000);
    rst = 1'b0;

    convert(0, 0, 1'b0);
    convert(4095, 0, 1'b0);
    convert(1234, 0, 1'b0);
    convert(42, 5, 1'b0);
    convert(7, 0, 1'b1);

    // Reset while the sixth iteration of 3000 is pending.
    bin_in = 12'd3000; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("mid_busy", in_ready, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrst_in_ready", in_ready, 1);
    check("midrst_valid", out_valid, 0);
    check("midrst_bcd", bcd_out, 16'h0000);
    check("midrst_ovf", ovf, 0);
    check("midrst_blank", digit_blank, 4'b0000);
    convert(3000, 0, 1'b0);

    for (int i = 0; i < 24; i++) begin
      v = int'($urandom_range(0, 4095));
      if (i < 4) v = i * 9;
      convert(v, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end

    convert14(12000);
    convert14(9999);
    convert14(10000);
    convert14(16383);
    for (int i = 0; i < 8; i++)
      convert14(int'($urandom_range(0, 16383)));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
